// File: rtl/uart_rx_fifo_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Shared types for the host-link receive FIFO.
//   byte_t : one received byte as carried between uart_rx and ram_rw.
//   BYTE_W : width of that byte.
// ----------------------------------------------------------------------------
package uart_rx_fifo_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage : uart_rx_fifo_pkg

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// Byte FIFO between uart_rx and ram_rw. It absorbs bursts while the loader is
// busy and applies back-pressure upstream instead of dropping bytes. The
// output is first-word-fall-through.
//
// Parameters
//   DEPTH : number of byte entries (power of two, >= 2)
//   AFULL : occupancy at or above which afull_o asserts (1..DEPTH)
//
// Ports
//   clk_i          : system clock
//   rst_n_i        : synchronous active-low reset (clears pointers)
//   in_data_i      : byte from uart_rx
//   in_data_vld_i  : in_data_i valid, held until accepted
//   in_data_rdy_o  : FIFO can accept a byte (not full)
//   out_data_o     : head byte to ram_rw
//   out_data_vld_o : head byte valid (not empty)
//   out_data_rdy_i : consumer takes the head byte
//   flush_i        : discard all contents on the next edge
//   level_o        : occupancy 0..DEPTH
//   empty_o        : level == 0
//   full_o         : level == DEPTH
//   afull_o        : level >= AFULL
// ----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AFULL = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [7:0]                 in_data_i,
  input  logic                       in_data_vld_i,
  output logic                       in_data_rdy_o,
  output logic [7:0]                 out_data_o,
  output logic                       out_data_vld_o,
  input  logic                       out_data_rdy_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       afull_o
);

  localparam int AW = $clog2(DEPTH);

  // Elaboration-time parameter sanity.
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two and >= 2");
  end
  if (AFULL < 1 || AFULL > DEPTH) begin : g_bad_afull
    $error("uart_rx_fifo: AFULL must be in 1..DEPTH");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  byte_t       r_mem [DEPTH];

  logic [AW:0] w_level;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  // All flags come from the registered pointers only, so in_data_rdy_o has
  // no combinational path from out_data_rdy_i.
  assign w_level = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr == {~r_rptr[AW], r_rptr[AW-1:0]});

  assign w_push  = in_data_vld_i && !w_full;
  assign w_pop   = out_data_rdy_i && !w_empty;

  // Pointer update: reset, then flush, override any handshake in that cycle.
  // A push coincident with flush still saw rdy high, so the source treats it
  // as accepted; the byte is simply discarded here.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is not reset or cleared on flush; it is only ever read through
  // a valid pointer range.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= in_data_i;
  end

  assign in_data_rdy_o  = !w_full;
  assign out_data_vld_o = !w_empty;
  assign out_data_o     = r_mem[r_rptr[AW-1:0]];
  assign level_o        = w_level;
  assign empty_o        = w_empty;
  assign full_o         = w_full;
  assign afull_o        = (w_level >= (AW+1)'(AFULL));

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo with DEPTH=16, AFULL=12: reset, fill,
// drain from full, steady concurrent traffic across pointer wrap, flush race
// and reset mid-stream.
// ----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_vld;
  logic       in_rdy;
  logic [7:0] out_data;
  logic       out_vld;
  logic       out_rdy;
  logic       flush;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       afull;

  int n_chk  = 0;
  int n_pass = 0;

  uart_rx_fifo #(.DEPTH(16), .AFULL(12)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .in_data_i      (in_data),
    .in_data_vld_i  (in_vld),
    .in_data_rdy_o  (in_rdy),
    .out_data_o     (out_data),
    .out_data_vld_o (out_vld),
    .out_data_rdy_i (out_rdy),
    .flush_i        (flush),
    .level_o        (level),
    .empty_o        (empty),
    .full_o         (full),
    .afull_o        (afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Advance one edge; inputs are then changed and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [7:0] first);
    out_rdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_data = first + 8'(i);
      in_vld  = 1'b1;
      tick();
    end
    in_vld = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_rdy"},   16'(in_rdy),  16'd1);
    check({pfx, "_vld"},   16'(out_vld), 16'd0);
    check({pfx, "_empty"}, 16'(empty),   16'd1);
    check({pfx, "_full"},  16'(full),    16'd0);
    check({pfx, "_afull"}, 16'(afull),   16'd0);
    check({pfx, "_level"}, 16'(level),   16'd0);
  endtask

  logic [7:0] wv, rv;
  logic       acc;

  initial begin
    rst_n   = 1'b0;
    in_data = 8'h00;
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    flush   = 1'b0;

    // ---- 1. reset ----
    repeat (3) tick();
    check_reset_vals("reset");
    rst_n = 1'b1;

    // ---- 2. fill ----
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i);
      in_vld  = 1'b1;
      tick();
      if (i == 10) check("fill_afull_11", 16'(afull), 16'd0);
      if (i == 11) check("fill_afull_12", 16'(afull), 16'd1);
      if (i == 14) check("fill_rdy_15",   16'(in_rdy), 16'd1);
    end
    check("fill_full",  16'(full),   16'd1);
    check("fill_rdy",   16'(in_rdy), 16'd0);
    check("fill_level", 16'(level),  16'd16);
    in_data = 8'hAA;
    in_vld  = 1'b1;
    tick();
    tick();
    check("fill_hold_level", 16'(level),    16'd16);
    check("fill_hold_head",  16'(out_data), 16'h00);

    // ---- 3. drain from full; 0xAA still presented ----
    out_rdy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("drain_vld",  16'(out_vld),  16'd1);
      check("drain_data", 16'(out_data), 16'(k));
      if (k == 0) check("drain_rdy_before", 16'(in_rdy), 16'd0);
      if (k == 1) begin
        check("drain_rdy_after", 16'(in_rdy), 16'd1);
        check("drain_level_1",   16'(level),  16'd15);
      end
      acc = in_vld && in_rdy;
      tick();
      if (acc) in_vld = 1'b0;
    end
    check("drain_aa_vld",  16'(out_vld),  16'd1);
    check("drain_aa_data", 16'(out_data), 16'hAA);
    tick();
    out_rdy = 1'b0;
    check("drain_empty", 16'(empty),   16'd1);
    check("drain_vldlo", 16'(out_vld), 16'd0);
    check("drain_level", 16'(level),   16'd0);

    // ---- 4. concurrent traffic at level 5 across wrap ----
    wv = 8'h30;
    rv = 8'h30;
    push_n(5, wv);
    wv = wv + 8'd5;
    check("conc_level_start", 16'(level), 16'd5);
    out_rdy = 1'b1;
    in_vld  = 1'b1;
    for (int c = 0; c < 100; c++) begin
      in_data = wv;
      check("conc_data",  16'(out_data), 16'(rv));
      check("conc_level", 16'(level),    16'd5);
      tick();
      wv = wv + 8'd1;
      rv = rv + 8'd1;
    end
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    check("conc_level_end", 16'(level),    16'd5);
    check("conc_head_end",  16'(out_data), 16'(rv));

    // ---- 5. flush race at level 7 ----
    push_n(2, wv);
    check("flush_level7", 16'(level), 16'd7);
    in_data = 8'h55;
    in_vld  = 1'b1;
    out_rdy = 1'b1;
    flush   = 1'b1;
    check("flush_rdy_pre", 16'(in_rdy), 16'd1);
    tick();
    flush   = 1'b0;
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    check("flush_level", 16'(level),   16'd0);
    check("flush_empty", 16'(empty),   16'd1);
    check("flush_vld",   16'(out_vld), 16'd0);
    tick();
    tick();
    check("flush_vld_later", 16'(out_vld), 16'd0);
    push_n(1, 8'h11);
    check("flush_next_data",  16'(out_data), 16'h11);
    check("flush_next_level", 16'(level),    16'd1);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check("flush_after_pop", 16'(empty), 16'd1);

    // ---- 6. reset mid-stream at level 9 ----
    push_n(9, 8'h80);
    check("rst_level9", 16'(level), 16'd9);
    in_data = 8'hC3;
    in_vld  = 1'b1;
    out_rdy = 1'b1;
    rst_n   = 1'b0;
    tick();
    rst_n   = 1'b1;
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    check_reset_vals("midrst");
    tick();
    tick();
    check("midrst_vld_later", 16'(out_vld), 16'd0);
    push_n(1, 8'h42);
    check("midrst_next_data",  16'(out_data), 16'h42);
    check("midrst_next_level", 16'(level),    16'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_uart_rx_fifo
